// File: rtl/seg_pkg.sv
// Shared definitions for the front-panel block: segment patterns, the blank
// pattern, and the digit-scan state encoding.
package seg_pkg;

  // Active-low segment patterns for hex digits 0..F, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All digit selects off.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // One state per display digit; the encoding doubles as the digit index.
  typedef enum logic [2:0] {
    DIG0 = 3'd0,
    DIG1 = 3'd1,
    DIG2 = 3'd2,
    DIG3 = 3'd3,
    DIG4 = 3'd4,
    DIG5 = 3'd5,
    DIG6 = 3'd6,
    DIG7 = 3'd7
  } scan_state_t;

  // Map a hex nibble to its active-low segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge pulse for a
// single raw switch/button input.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic debounced,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] stable_cnt;
  logic          deb_prev;

  // Bring the asynchronous input into the clock domain before it is used.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive cycles that disagree with the filtered level; any
  // agreeing cycle restarts the window, so only a sustained change flips it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      debounced  <= 1'b0;
    end else if (sync_p1 == debounced) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      debounced  <= ~debounced;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Registered rising-edge detect: one pulse the cycle after the level rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_prev   <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      deb_prev   <= debounced;
      rise_pulse <= debounced & ~deb_prev;
    end
  end

endmodule

// File: rtl/seven_seg_debounce_unit.sv
// Front-panel I/O: debounced switch with rising-edge pulse, plus an 8-digit
// multiplexed common-anode seven-segment display of an 8-bit value in
// decimal (three digits) or hex (two digits).
module seven_seg_debounce_unit
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_CYCLES  = 100_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_in,
  output logic       debounced,
  output logic       rise_pulse,
  input  logic       mode,
  input  logic [7:0] value,
  input  logic [7:0] digit_en,
  output logic [6:0] cathode,
  output logic [7:0] anode
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  scan_state_t   state;
  logic [RW-1:0] refresh_cnt;
  logic [11:0]   bcd;
  logic [3:0]    nibble;
  logic          has_content;
  logic [2:0]    digit_idx;
  logic [7:0]    anode_next;
  logic [6:0]    cathode_next;

  // Binary to three BCD digits by shift-and-add-3 (hundreds, tens, ones).
  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [19:0] s;
    s = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
      if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
      if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
      s = s << 1;
    end
    return s[19:8];
  endfunction

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .raw_in    (raw_in),
    .debounced (debounced),
    .rise_pulse(rise_pulse)
  );

  assign bcd       = to_bcd(value);
  assign digit_idx = 3'(state);

  // Select the nibble shown on the current digit and whether it has content.
  always_comb begin
    nibble      = 4'd0;
    has_content = 1'b0;
    if (mode) begin
      case (state)
        DIG0: begin nibble = bcd[3:0];  has_content = 1'b1; end
        DIG1: begin nibble = bcd[7:4];  has_content = 1'b1; end
        DIG2: begin nibble = bcd[11:8]; has_content = 1'b1; end
        default: begin nibble = 4'd0;   has_content = 1'b0; end
      endcase
    end else begin
      case (state)
        DIG0: begin nibble = value[3:0]; has_content = 1'b1; end
        DIG1: begin nibble = value[7:4]; has_content = 1'b1; end
        default: begin nibble = 4'd0;    has_content = 1'b0; end
      endcase
    end
  end

  // Light the current digit only if it carries content and is enabled.
  always_comb begin
    anode_next   = ANODE_OFF;
    cathode_next = SEG_BLANK;
    if (has_content && digit_en[digit_idx]) begin
      anode_next   = ~(8'd1 << digit_idx);
      cathode_next = seg_decode(nibble);
    end
  end

  // Scan FSM: hold each digit for REFRESH_CYCLES cycles, then move to the next.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= DIG0;
      refresh_cnt <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      case (state)
        DIG0:    state <= DIG1;
        DIG1:    state <= DIG2;
        DIG2:    state <= DIG3;
        DIG3:    state <= DIG4;
        DIG4:    state <= DIG5;
        DIG5:    state <= DIG6;
        DIG6:    state <= DIG7;
        default: state <= DIG0;
      endcase
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Register the display drive so the pins change cleanly on the clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode   <= ANODE_OFF;
      cathode <= SEG_BLANK;
    end else begin
      anode   <= anode_next;
      cathode <= cathode_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_debounce_unit.sv
// Directed bench for seven_seg_debounce_unit with short debounce/refresh
// windows; display expectations are queued ahead of each clock and popped
// when the registered outputs are sampled.
module tb_seven_seg_debounce_unit;

  localparam int DEB = 8;
  localparam int REF = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       raw_in;
  logic       debounced;
  logic       rise_pulse;
  logic       mode;
  logic [7:0] value;
  logic [7:0] digit_en;
  logic [6:0] cathode;
  logic [7:0] anode;

  int checks = 0;
  int passes = 0;
  int n      = 0;   // clock edges since reset release
  int pulse_cnt = 0;
  int rise_cnt  = 0;
  logic deb_q = 1'b0;

  string      sb_tag [$];
  logic [7:0] sb_exp [$];

  seven_seg_debounce_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_CYCLES (REF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw_in    (raw_in),
    .debounced (debounced),
    .rise_pulse(rise_pulse),
    .mode      (mode),
    .value     (value),
    .digit_en  (digit_en),
    .cathode   (cathode),
    .anode     (anode)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Push the anode/cathode expected after the coming edge (edge number n+1).
  task automatic predict_display();
    int d, nib, e;
    bit has;
    logic [7:0] an;
    logic [6:0] ca;
    e = n + 1;
    d = ((e - 1) / REF) % 8;
    if (mode) begin
      has = (d < 3);
      nib = (d == 0) ? int'(value) % 10 : (d == 1) ? (int'(value) / 10) % 10 : int'(value) / 100;
    end else begin
      has = (d < 2);
      nib = (d == 0) ? int'(value) % 16 : int'(value) / 16;
    end
    if (has && digit_en[d]) begin
      an = ~(8'd1 << d);
      ca = seg_ref(nib);
    end else begin
      an = 8'hFF;
      ca = 7'h7F;
    end
    sb_tag.push_back($sformatf("anode_e%0d_d%0d", e, d));
    sb_exp.push_back(an);
    sb_tag.push_back($sformatf("cathode_e%0d_d%0d", e, d));
    sb_exp.push_back({1'b0, ca});
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    n++;
    if (rise_pulse) pulse_cnt++;
    if (debounced && !deb_q) rise_cnt++;
    deb_q = debounced;
  endtask

  task automatic compare_display();
    string t;
    logic [7:0] x;
    if (sb_exp.size() < 2) begin
      check("scoreboard_empty", 32'(sb_exp.size()), 32'd2);
    end else begin
      t = sb_tag.pop_front(); x = sb_exp.pop_front();
      check(t, {24'd0, anode}, {24'd0, x});
      t = sb_tag.pop_front(); x = sb_exp.pop_front();
      check(t, {25'd0, cathode}, {24'd0, x});
    end
  endtask

  initial begin
    int lat;
    bit dropped;

    reset    = 1'b1;
    raw_in   = 1'b0;
    mode     = 1'b1;
    value    = 8'd173;
    digit_en = 8'hFF;
    repeat (3) @(negedge clock);
    check("rst_anode",      {24'd0, anode},   32'hFF);
    check("rst_cathode",    {25'd0, cathode}, 32'h7F);
    check("rst_debounced",  {31'd0, debounced},  32'd0);
    check("rst_rise_pulse", {31'd0, rise_pulse}, 32'd0);
    reset = 1'b0;
    n = 0;

    // Decimal 173 across one full frame.
    repeat (8 * REF) begin
      predict_display();
      tick();
      compare_display();
    end

    // Hex 0xAD with alternate digits enabled; change takes effect next edge.
    mode = 1'b0; value = 8'hAD; digit_en = 8'b1010_1010;
    repeat (8 * REF) begin
      predict_display();
      tick();
      compare_display();
    end

    // Bouncing input: 3-cycle runs never reach the debounce window.
    pulse_cnt = 0; rise_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      raw_in = ~raw_in;
      repeat (3) tick();
    end
    check("bounce_no_rise",  32'(rise_cnt), 32'd0);
    check("bounce_deb_low",  {31'd0, debounced}, 32'd0);
    raw_in = 1'b1;
    lat = 0;
    while (!debounced && lat < 40) begin
      tick();
      lat++;
    end
    check("rise_latency_in_window", {31'd0, (lat >= DEB + 1 && lat <= DEB + 3)}, 32'd1);
    check("pulse_not_same_cycle", {31'd0, rise_pulse}, 32'd0);
    tick();
    check("pulse_next_cycle", {31'd0, rise_pulse}, 32'd1);
    tick();
    check("pulse_one_cycle", {31'd0, rise_pulse}, 32'd0);
    repeat (10) tick();
    check("rise_count_once",  32'(rise_cnt),  32'd1);
    check("pulse_count_once", 32'(pulse_cnt), 32'd1);
    check("deb_high_held",    {31'd0, debounced}, 32'd1);

    // A low glitch one cycle shorter than the window must not propagate.
    dropped = 1'b0;
    raw_in = 1'b0;
    repeat (DEB - 1) begin tick(); if (!debounced) dropped = 1'b1; end
    raw_in = 1'b1;
    repeat (20) begin tick(); if (!debounced) dropped = 1'b1; end
    check("glitch_no_prop", {31'd0, dropped}, 32'd0);

    // Falling edge: level drops after the window, no pulse.
    raw_in = 1'b0;
    lat = 0;
    while (debounced && lat < 40) begin
      tick();
      lat++;
    end
    check("fall_latency_in_window", {31'd0, (lat >= DEB + 1 && lat <= DEB + 3)}, 32'd1);
    repeat (5) tick();
    check("no_fall_pulse", 32'(pulse_cnt), 32'd1);
    check("deb_low_after_fall", {31'd0, debounced}, 32'd0);

    // Asynchronous reset while digit 1 is lit and debounce is mid-count.
    mode = 1'b1; value = 8'd173; digit_en = 8'hFF;
    lat = 0;
    while ((n % (8 * REF)) != 0 && lat < 40) begin
      tick();
      lat++;
    end
    raw_in = 1'b1;
    repeat (6) tick();
    check("pre_reset_anode",   {24'd0, anode},   32'hFD);
    check("pre_reset_cathode", {25'd0, cathode}, 32'h78);
    check("pre_reset_midcount", {31'd0, debounced}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_anode",   {24'd0, anode},   32'hFF);
    check("async_rst_cathode", {25'd0, cathode}, 32'h7F);
    check("async_rst_deb",     {31'd0, debounced},  32'd0);
    check("async_rst_pulse",   {31'd0, rise_pulse}, 32'd0);
    raw_in = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    predict_display();
    tick();
    compare_display();
    repeat (2 * DEB) tick();
    check("post_reset_deb_low", {31'd0, debounced}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
